// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the
// bit-serial adder. The optional overflow output is enabled by the
// SERIAL_ADDER_OVF_EN macro (see serial_adder.sv).
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result buses.
// Handshake: the controller raises start with a and b valid; the adder
// accepts only while idle (busy low), then busy stays high until the cycle
// after the one-cycle done pulse, during which sum/cout are valid.
// A start seen while busy is dropped, not queued.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
// state is a read-only view of the FSM for observation.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif
    state_t           state;

    modport master (
        output start, a, b,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout, state
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: the single one-bit datapath cell of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum bit and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one bit per clock
// through one full_adder and a carry flop. IDLE -> RUN (WIDTH cycles) ->
// DONE (1 cycle) -> IDLE. Define SERIAL_ADDER_OVF_EN to add the signed
// overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // FSM, bit counter, shift registers and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        sum_sr <= '0;
                        // The previous result is withdrawn on acceptance.
                        sum_q  <= '0;
                        cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q  <= 1'b0;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Final bit: publish the sum including this bit.
                        sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
                        cout_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB differs from carry out of it.
                        ovf_q  <= carry ^ fa_cout;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are registers or decodes of the registered state.
    always_comb begin
        bus.busy  = (state == RUN) || (state == DONE);
        bus.done  = (state == DONE);
        bus.sum   = sum_q;
        bus.cout  = cout_q;
        bus.state = state;
`ifdef SERIAL_ADDER_OVF_EN
        bus.ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH=8)
// against an arithmetic reference model. Checks ovf when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;

    // {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition, signed overflow by range test.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int u;
        int sx;
        int sy;
        logic ov;
        logic [31:0] uv;
        u  = int'(x) + int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ov = ((sx + sy) > 127) || ((sx + sy) < -128);
        uv = u;
        return {ov, uv[W:0]};
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("sum", bus.sum, e[W-1:0]);
                check("cout", bus.cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", bus.ovf, e[W+1]);
`endif
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One add; optionally pokes a second start at RUN cycle 'poke'.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
        logic [W+1:0] e;
        int k;
        int busy_cyc;
        int d0;
        e  = model(x, y);
        d0 = done_cnt;
        @(negedge clk);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        check("accept_busy", bus.busy, 1);
        check("accept_sum_clear", bus.sum, 0);
        check("accept_no_done", bus.done, 0);
        k = 1;
        busy_cyc = 1;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.busy) busy_cyc++;
            if (k == poke) begin
                bus.a = 8'hAA;
                bus.b = 8'hAA;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("done_latency", k, W + 1);
        @(negedge clk);
        check("busy_cycles", busy_cyc, W + 1);
        check("busy_fall", bus.busy, 0);
        check("done_single", bus.done, 0);
        check("sum_held", bus.sum, e[W-1:0]);
        check("cout_held", bus.cout, e[W]);
        idle_cycles(2);
        check("one_done_per_add", done_cnt - d0, 1);
    endtask

    initial begin
        int cyc;
        int pulses;
        int t[3];
        int d0;
        checks = 0;
        failures = 0;
        done_cnt = 0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // Reset state
        rst = 1'b1;
        idle_cycles(3);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_state", bus.state, IDLE);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
        // Start under reset must not be accepted.
        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        @(negedge clk);
        check("rst_start_ignored", bus.busy, 0);
        bus.start = 1'b0;
        rst = 1'b0;
        idle_cycles(2);
        check("rst_release_idle", bus.busy, 0);

        // Directed vectors
        do_add(8'h3C, 8'h5A, 0);
        do_add(8'hFF, 8'h01, 0);
        do_add(8'h7F, 8'h01, 0);
        do_add(8'h80, 8'h80, 0);
        do_add(8'h00, 8'h00, 0);
        do_add(8'hFF, 8'hFF, 0);

        // Start during RUN is dropped
        do_add(8'h11, 8'h22, 3);
        idle_cycles(12);
        check("poke_no_extra", done_cnt, 7);
        check("poke_idle", bus.busy, 0);

        // Reset in the middle of RUN
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 8'hF0;
        bus.b = 8'h0F;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        check("midrst_done", bus.done, 0);
        idle_cycles(12);
        check("midrst_no_done", done_cnt - d0, 0);
        do_add(8'h01, 8'h02, 0);

        // Continuous start: one add per W+2 cycles
        @(negedge clk);
        bus.a = 8'h05;
        bus.b = 8'h06;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h05, 8'h06));
        cyc = 0;
        pulses = 0;
        while (pulses < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                t[pulses] = cyc;
                pulses++;
                if (pulses == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("stream_pulses", pulses, 3);
        check("stream_first", t[0], W + 1);
        check("stream_gap1", t[1] - t[0], W + 2);
        check("stream_gap2", t[2] - t[1], W + 2);
        idle_cycles(4);
        check("stream_idle", bus.busy, 0);

        // Random operands with random idle gaps
        for (int i = 0; i < 30; i++) begin
            do_add(W'($urandom), W'($urandom), 0);
            idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(3);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder, the additive counterpart to the team's subtractor cells. Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. Used where area matters more than latency: one full adder instead of a WIDTH-bit ripple chain. A start/busy/done handshake lets a controller launch an add and collect the sum.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- a  input  WIDTH  augend; captured on the accepting edge
- b  input  WIDTH  addend; captured on the accepting edge
- busy  output  1  high while in RUN or DONE
- done  output  1  single-cycle completion pulse
- sum  output  WIDTH  result; holds its value until the next accepted start or reset
- cout  output  1  carry out of the MSB; held like sum
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle for WIDTH cycles.
  - DONE: asserts done for one cycle.
- IDLE -> RUN when start=1:
  - Load a and b into the operand shift registers.
  - Clear the carry flip-flop and the bit counter.
  - Clear the sum shift register.
- Each RUN edge:
  - Compute s = a_sr[0] ^ b_sr[0] ^ c and c_next = majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by one.
  - Shift s into sum_sr from the MSB end, so sum_sr is shifted right.
  - Update c <= c_next and increment the counter.
- RUN -> DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1):
  - That same edge transfers sum_sr (including the final bit) to sum and c_next to cout.
- DONE -> IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. There is no queueing; a dropped request must be re-issued.
- a and b may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. cout is the true carry, so {cout,sum} equals a+b exactly.
- Reset is synchronous and takes priority over everything, including mid-RUN:
  - State goes to IDLE; counter, carry, shift registers, sum, cout, done and ovf all go to 0.
  - No partial result is exposed.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.
- All outputs are registered, or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Latency: done is high during the cycle following the WIDTH-th clock edge after the edge that accepted start.
  - Total occupancy is WIDTH+1 cycles (WIDTH RUN + 1 DONE).
- busy rises on the accepting edge and falls on the edge that leaves DONE.
- sum and cout become valid in the same cycle that done is high. They remain stable until the next accepting edge, which clears them.
- Maximum throughput is one add per WIDTH+2 cycles: a start held high continuously is accepted in the first IDLE cycle after DONE.
- Simultaneous rst and start: rst wins, and the operation is not accepted.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port exists and is set to c_in(bit WIDTH-1) ^ c_out(bit WIDTH-1).
  - ovf is captured on the final RUN edge and held and cleared exactly like cout.
- SERIAL_ADDER_OVF_EN undefined:
  - No ovf port and no overflow logic.
  - All other behaviour is identical.

## Structure
- serial_adder_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default width constant.
- The counter width is $clog2(WIDTH), declared locally.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout) is the single datapath cell, instantiated once.
- The FSM, counter and shift registers stay in serial_adder.

## Test plan
- WIDTH=8, start with a=8'h3C, b=8'h5A -> done 8 edges after acceptance; sum=8'h96, cout=0, busy high for 9 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
- SERIAL_ADDER_OVF_EN, a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- Pulse start with a=8'h11, b=8'h22, then pulse start with a=8'hAA, b=8'hAA at RUN cycle 3 -> second request ignored; sum=8'h33, exactly one done pulse.
- Assert rst during RUN cycle 4 of a=8'hF0, b=8'h0F -> next cycle busy=0, sum=0, cout=0, no done; a following start with a=8'h01, b=8'h02 yields sum=8'h03.
- Hold start=1 continuously with a=8'h05, b=8'h06 -> done pulses every 10 cycles, each with sum=8'h0B.
